// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive framing controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, default sync marker, checksum add,
//           clog2 helper and inter-byte timeout cycle calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CKSUM   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Running 8-bit checksum; wraps modulo 256 by construction.
  function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Inter-byte gap limit in clocks: whole bit periods times clocks per bit.
  function automatic int to_cyc(input int clk_hz, input int baud, input int bits);
    return bits * (clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one sync write port, one comb read port.
// Latency: write visible on the cycle after i_wr_en; read is combinational.
// Backpressure: none; the owner never writes and reads the same frame concurrently.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_addr -> o_rd_data read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences uart_rx: accepts/acks bytes, parses SYNC LEN payload CKSUM frames, releases verified payloads.
// Latency: CKSUM accept at cycle T -> rx_ack, frm_ok and first out_valid at T+1.
// Backpressure: out_ready low holds out_data/out_last; bytes arriving while draining are acked, dropped, err_overrun.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid in, rx_ack out (uart_rx soft_reset);
//        out_data/out_valid/out_ready/out_last payload stream; frm_ok, err_* one-cycle status pulses.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         CLOCK_FREQ   = 38400000,
  parameter int         BAUD_RATE    = 9600,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ack,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frm_ok,
  output logic       err_cksum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int               TO_CYC    = to_cyc(CLOCK_FREQ, BAUD_RATE, TIMEOUT_BITS);
  localparam int               CNT_W     = clog2(TO_CYC + 1);
  localparam int               AW        = (MAX_LEN > 1) ? clog2(MAX_LEN) : 1;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);

  state_t           r_state;
  logic             r_rx_valid_q;
  logic [7:0]       r_len;
  logic [7:0]       r_sum;
  logic [7:0]       r_wr_idx;
  logic [7:0]       r_rd_idx;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_rx_ack;
  logic             r_frm_ok;
  logic             r_err_cksum;
  logic             r_err_len;
  logic             r_err_timeout;
  logic             r_err_overrun;

  state_t           w_state_nxt;
  logic [7:0]       w_len_nxt;
  logic [7:0]       w_sum_nxt;
  logic [7:0]       w_wr_idx_nxt;
  logic [7:0]       w_rd_idx_nxt;
  logic             w_ok_nxt;
  logic             w_ecks_nxt;
  logic             w_elen_nxt;
  logic             w_eto_nxt;
  logic             w_eovr_nxt;
  logic             w_buf_we;
  logic             w_acc;
  logic             w_to_run;
  logic             w_to_expire;
  logic             w_last;
  logic [7:0]       w_rd_dat;

  // Rising edge of the level valid: a held level is taken exactly once.
  assign w_acc       = rx_valid & ~r_rx_valid_q;
  assign w_to_run    = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CKSUM);
  // An accept in the expiry cycle wins over the timeout.
  assign w_to_expire = w_to_run && !w_acc && (r_to_cnt == TO_LAST);
  assign w_last      = (r_rd_idx == (r_len - 8'd1));

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_buf_we),
    .i_wr_addr (r_wr_idx[AW-1:0]),
    .i_wr_data (rx_data),
    .i_rd_addr (r_rd_idx[AW-1:0]),
    .o_rd_data (w_rd_dat)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_sum_nxt    = r_sum;
    w_wr_idx_nxt = r_wr_idx;
    w_rd_idx_nxt = r_rd_idx;
    w_ok_nxt     = 1'b0;
    w_ecks_nxt   = 1'b0;
    w_elen_nxt   = 1'b0;
    w_eto_nxt    = 1'b0;
    w_eovr_nxt   = 1'b0;
    w_buf_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && (rx_data == SYNC_BYTE)) w_state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (w_acc) begin
          w_len_nxt = rx_data;
          w_sum_nxt = rx_data;
          if (rx_data > MAX_LEN_B) begin
            w_elen_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (rx_data == 8'd0) begin
            w_state_nxt = ST_CKSUM;
          end else begin
            w_wr_idx_nxt = 8'd0;
            w_state_nxt  = ST_PAYLOAD;
          end
        end else if (w_to_expire) begin
          w_eto_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (w_acc) begin
          w_buf_we     = 1'b1;
          w_sum_nxt    = cksum_add(r_sum, rx_data);
          w_wr_idx_nxt = r_wr_idx + 8'd1;
          if (r_wr_idx == (r_len - 8'd1)) w_state_nxt = ST_CKSUM;
        end else if (w_to_expire) begin
          w_eto_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CKSUM: begin
        if (w_acc) begin
          if (cksum_add(r_sum, rx_data) == 8'h00) begin
            w_ok_nxt = 1'b1;
            if (r_len != 8'd0) begin
              w_rd_idx_nxt = 8'd0;
              w_state_nxt  = ST_DRAIN;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_ecks_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_to_expire) begin
          w_eto_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The buffer is not written here, so a stalled beat stays stable.
        if (w_acc) w_eovr_nxt = 1'b1;
        if (out_ready) begin
          w_rd_idx_nxt = r_rd_idx + 8'd1;
          if (w_last) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rx_valid_q  <= 1'b0;
      r_len         <= 8'd0;
      r_sum         <= 8'd0;
      r_wr_idx      <= 8'd0;
      r_rd_idx      <= 8'd0;
      r_to_cnt      <= '0;
      r_rx_ack      <= 1'b0;
      r_frm_ok      <= 1'b0;
      r_err_cksum   <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rx_valid_q  <= rx_valid;
      r_len         <= w_len_nxt;
      r_sum         <= w_sum_nxt;
      r_wr_idx      <= w_wr_idx_nxt;
      r_rd_idx      <= w_rd_idx_nxt;
      r_to_cnt      <= (w_acc || !w_to_run) ? '0 : r_to_cnt + CNT_W'(1);
      r_rx_ack      <= w_acc;
      r_frm_ok      <= w_ok_nxt;
      r_err_cksum   <= w_ecks_nxt;
      r_err_len     <= w_elen_nxt;
      r_err_timeout <= w_eto_nxt;
      r_err_overrun <= w_eovr_nxt;
    end
  end

  assign out_valid   = (r_state == ST_DRAIN);
  // Gated so the don't-care buffer contents never reach the port outside a drain.
  assign out_data    = out_valid ? w_rd_dat : 8'h00;
  assign out_last    = out_valid && w_last;
  assign rx_ack      = r_rx_ack;
  assign frm_ok      = r_frm_ok;
  assign err_cksum   = r_err_cksum;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: scenario tasks plus a beat scoreboard.
// Timing: inputs driven on the falling edge, outputs sampled 1 time unit after it.
// Timeout scaled to 800 clocks (20 bits x 40 clocks/bit) to keep the run short.
module tb_uart_rx_frame_ctrl;

  localparam int CLK_HZ  = 384000;
  localparam int BAUD    = 9600;
  localparam int TO_BITS = 20;
  localparam int EXP_TO  = 800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frm_ok, err_cksum, err_len, err_timeout, err_overrun;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .CLOCK_FREQ   (CLK_HZ),
    .BAUD_RATE    (BAUD),
    .MAX_LEN      (16),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frm_ok      (frm_ok),
    .err_cksum   (err_cksum),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int c_ack, c_ok, c_cks, c_len, c_to, c_ovr, c_beat;

  // Monitor: counts pulses, enforces one status pulse per cycle, scores beats.
  always begin
    @(negedge clk);
    #1;
    if (rx_ack)      c_ack++;
    if (frm_ok)      c_ok++;
    if (err_cksum)   c_cks++;
    if (err_len)     c_len++;
    if (err_timeout) c_to++;
    if (err_overrun) c_ovr++;
    n_cmp++;
    if ($countones({frm_ok, err_cksum, err_len, err_timeout, err_overrun}) > 1) begin
      n_bad++;
      $display("FAIL pulse_onehot: got %b want at most one set", {frm_ok, err_cksum, err_len, err_timeout, err_overrun});
    end
    if (out_valid && out_ready) begin
      c_beat++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got %02h last=%0b want no beat", out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_data, out_last} !== mon_e) begin
          n_bad++;
          $display("FAIL beat_data: got %02h last=%0b want %02h last=%0b", out_data, out_last, mon_e.dat, mon_e.last);
        end
      end
    end
  end

  task automatic clear_counts();
    c_ack = 0; c_ok = 0; c_cks = 0; c_len = 0; c_to = 0; c_ovr = 0; c_beat = 0;
  endtask

  // Mimics uart_rx: raise valid, drop it once the ack is back.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({rx_ack, out_data, out_valid, out_last, frm_ok, err_cksum, err_len, err_timeout, err_overrun} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {rx_ack, out_data, out_valid, out_last, frm_ok, err_cksum, err_len, err_timeout, err_overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    clear_counts();
    out_ready = 1'b1;
    exp_q.push_back({8'h11, 1'b0});
    exp_q.push_back({8'h22, 1'b0});
    exp_q.push_back({8'h33, 1'b1});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    #1;
    n_cmp++;
    if ({frm_ok, rx_ack, out_valid, out_data, out_last} !== {3'b111, 8'h11, 1'b0}) begin
      n_bad++;
      $display("FAIL good_first_cycle: got ok=%0b ack=%0b v=%0b d=%02h l=%0b want 1 1 1 11 0", frm_ok, rx_ack, out_valid, out_data, out_last);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({out_valid, out_data, out_last} !== {1'b1, 8'h22, 1'b0}) begin
      n_bad++;
      $display("FAIL good_beat2: got v=%0b d=%02h l=%0b want 1 22 0", out_valid, out_data, out_last);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({out_valid, out_data, out_last} !== {1'b1, 8'h33, 1'b1}) begin
      n_bad++;
      $display("FAIL good_beat3: got v=%0b d=%02h l=%0b want 1 33 1", out_valid, out_data, out_last);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL good_valid_drop: got %0b want 0", out_valid);
    end
    idle(3);
    n_cmp++;
    if (c_ack != 6 || c_ok != 1 || c_beat != 3 || exp_q.size() != 0 || (c_cks + c_len + c_to + c_ovr) != 0) begin
      n_bad++;
      $display("FAIL good_counts: got ack=%0d ok=%0d beats=%0d q=%0d errs=%0d want 6 1 3 0 0", c_ack, c_ok, c_beat, exp_q.size(), c_cks + c_len + c_to + c_ovr);
    end
  endtask

  task automatic test_backpressure();
    clear_counts();
    out_ready = 1'b0;
    exp_q.push_back({8'h11, 1'b0});
    exp_q.push_back({8'h22, 1'b0});
    exp_q.push_back({8'h33, 1'b1});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 1) begin
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
      end
      if (i == 2) rx_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out_data, out_last} !== {1'b1, 8'h11, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got v=%0b d=%02h l=%0b want 1 11 0", i, out_valid, out_data, out_last);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    idle(5);
    n_cmp++;
    if (c_ovr != 1 || c_ack != 7 || c_ok != 1 || c_beat != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_counts: got ovr=%0d ack=%0d ok=%0d beats=%0d q=%0d want 1 7 1 3 0", c_ovr, c_ack, c_ok, c_beat, exp_q.size());
    end
  endtask

  task automatic test_bad_cksum_len();
    clear_counts();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    idle(3);
    n_cmp++;
    if (c_cks != 1 || c_ok != 0 || c_beat != 0) begin
      n_bad++;
      $display("FAIL cksum_err: got cks=%0d ok=%0d beats=%0d want 1 0 0", c_cks, c_ok, c_beat);
    end
    send_byte(8'hA5); send_byte(8'h11);
    idle(3);
    n_cmp++;
    if (c_len != 1) begin
      n_bad++;
      $display("FAIL len_err: got %0d want 1", c_len);
    end
    exp_q.push_back({8'h55, 1'b1});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA);
    idle(4);
    n_cmp++;
    if (c_ok != 1 || c_beat != 1 || exp_q.size() != 0 || c_ack != 11 || c_cks != 1 || c_len != 1) begin
      n_bad++;
      $display("FAIL after_len_err: got ok=%0d beats=%0d q=%0d ack=%0d cks=%0d len=%0d want 1 1 0 11 1 1", c_ok, c_beat, exp_q.size(), c_ack, c_cks, c_len);
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    for (int k = 1; k <= EXP_TO; k++) begin
      @(negedge clk);
      if (k == EXP_TO - 1) begin
        #1;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
          n_bad++;
          $display("FAIL timeout_early: got %0b want 0", err_timeout);
        end
      end
    end
    #1;
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_pulse: got %0b want 1", err_timeout);
    end
    idle(3);
    n_cmp++;
    if (c_to != 1 || c_ok != 0) begin
      n_bad++;
      $display("FAIL timeout_counts: got to=%0d ok=%0d want 1 0", c_to, c_ok);
    end
    // Byte landing exactly in the expiry cycle keeps the frame alive.
    clear_counts();
    exp_q.push_back({8'h10, 1'b0});
    exp_q.push_back({8'h20, 1'b1});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    repeat (EXP_TO - 2) @(negedge clk);
    send_byte(8'h20);
    send_byte(8'hCE);
    idle(5);
    n_cmp++;
    if (c_to != 0 || c_ok != 1 || c_beat != 2 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_suppress: got to=%0d ok=%0d beats=%0d q=%0d want 0 1 2 0", c_to, c_ok, c_beat, exp_q.size());
    end
  endtask

  task automatic test_idle_noise_zero_len();
    clear_counts();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(3);
    n_cmp++;
    if (c_ack != 3 || (c_ok + c_cks + c_len + c_to + c_ovr) != 0) begin
      n_bad++;
      $display("FAIL idle_noise: got ack=%0d pulses=%0d want 3 0", c_ack, c_ok + c_cks + c_len + c_to + c_ovr);
    end
    clear_counts();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    n_cmp++;
    if (c_ok != 1 || c_beat != 0 || c_cks != 0) begin
      n_bad++;
      $display("FAIL zero_len: got ok=%0d beats=%0d cks=%0d want 1 0 0", c_ok, c_beat, c_cks);
    end
    clear_counts();
    @(negedge clk);
    rx_data  = 8'h3C;
    rx_valid = 1'b1;
    idle(100);
    rx_valid = 1'b0;
    idle(3);
    n_cmp++;
    if (c_ack != 1) begin
      n_bad++;
      $display("FAIL held_level: got acks=%0d want 1", c_ack);
    end
  endtask

  task automatic test_reset_mid_payload();
    clear_counts();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rx_ack, out_data, out_valid, out_last, frm_ok, err_cksum, err_len, err_timeout, err_overrun} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", {rx_ack, out_data, out_valid, out_last, frm_ok, err_cksum, err_len, err_timeout, err_overrun});
    end
    exp_q.push_back({8'h07, 1'b1});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'hF8);
    idle(4);
    n_cmp++;
    if (c_ok != 1 || c_beat != 1 || exp_q.size() != 0 || (c_cks + c_len + c_to + c_ovr) != 0) begin
      n_bad++;
      $display("FAIL reset_then_frame: got ok=%0d beats=%0d q=%0d errs=%0d want 1 1 0 0", c_ok, c_beat, exp_q.size(), c_cks + c_len + c_to + c_ovr);
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_cksum_len();
    test_timeout();
    test_idle_noise_zero_len();
    test_reset_mid_payload();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
